// File: rtl/b8b10_pkg.sv
// Shared types and constants for the 8b/10b transmit controller.
// Compile-time option B8B10_CCOMP_EN (see b8b10_tx_ctrl) lives in the top file.
package b8b10_pkg;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_SYNC = 2'd1,
      ST_DATA = 2'd2
   } state_e;

   localparam logic [7:0] K28_5  = 8'hBC;
   localparam logic       RD_NEG = 1'b0;
   localparam logic       RD_POS = 1'b1;

   function automatic logic [3:0] popcount10(input logic [9:0] code);
      logic [3:0] n;
      n = '0;
      for (int unsigned i = 0; i < 10; i++) begin
         n = n + {3'b000, code[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/b8b10_rd_track.sv
// Running-disparity tracker: follows codeword weight and flags illegal weights
// (sticky until reset).
module b8b10_rd_track
   import b8b10_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] enc_code,
   input  logic       enc_valid,
   output logic       enc_rd,
   output logic       code_err
);

   logic [3:0] weight;
   logic       rd_q, rd_d;
   logic       err_q, err_d;

   always_comb begin
      weight = popcount10(enc_code);
      rd_d   = rd_q;
      err_d  = err_q;
      if (enc_valid) begin
         // Balanced (weight 5) codewords leave disparity unchanged
         if (weight > 4'd5) begin
            rd_d = RD_POS;
         end else if (weight < 4'd5) begin
            rd_d = RD_NEG;
         end
         if (weight < 4'd4 || weight > 4'd6) begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_q  <= RD_NEG;
         err_q <= 1'b0;
      end else begin
         rd_q  <= rd_d;
         err_q <= err_d;
      end
   end

   assign enc_rd   = rd_q;
   assign code_err = err_q;

endmodule

// File: rtl/b8b10_tx_ctrl.sv
// 8b/10b transmit controller: OFF -> SYNC (K28.5 commas) -> DATA payload.
// Define B8B10_CCOMP_EN to insert a clock-compensation comma every CCOMP_PERIOD DATA cycles.
module b8b10_tx_ctrl
   import b8b10_pkg::*;
#(
   parameter int unsigned SYNC_LEN     = 16,
   parameter int unsigned CCOMP_PERIOD = 256
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       link_en,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   output logic       s_ready,
   output logic [7:0] enc_data,
   output logic       enc_k,
   output logic       enc_valid,
   output logic       enc_rd,
   input  logic [9:0] enc_code,
   output logic       link_up,
   output logic       code_err
);

   if (SYNC_LEN < 1 || SYNC_LEN > 255 || CCOMP_PERIOD < 2 || CCOMP_PERIOD > 65535) begin : g_bad_param
      $error("b8b10_tx_ctrl: SYNC_LEN or CCOMP_PERIOD out of range");
   end

   localparam logic [7:0] SYNC_LAST = 8'(SYNC_LEN - 1);

   state_e     state_q, state_d;
   logic [7:0] sync_cnt_q, sync_cnt_d;
   logic       link_up_q, link_up_d;
   logic       comp_due;
   logic       accept;

`ifdef B8B10_CCOMP_EN
   localparam logic [15:0] CCOMP_LAST = 16'(CCOMP_PERIOD - 1);

   logic [15:0] ccomp_cnt_q, ccomp_cnt_d;

   assign comp_due = (state_q == ST_DATA) && (ccomp_cnt_q == CCOMP_LAST);

   always_comb begin
      ccomp_cnt_d = '0;
      if (link_en && state_q == ST_DATA) begin
         ccomp_cnt_d = comp_due ? '0 : ccomp_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ccomp_cnt_q <= '0;
      end else begin
         ccomp_cnt_q <= ccomp_cnt_d;
      end
   end
`else
   assign comp_due = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      sync_cnt_d = sync_cnt_q;
      link_up_d  = link_up_q;
      if (!link_en) begin
         state_d    = ST_OFF;
         sync_cnt_d = '0;
         link_up_d  = 1'b0;
      end else begin
         case (state_q)
            ST_OFF: begin
               state_d    = ST_SYNC;
               sync_cnt_d = '0;
            end
            ST_SYNC: begin
               if (sync_cnt_q == SYNC_LAST) begin
                  state_d    = ST_DATA;
                  sync_cnt_d = '0;
                  link_up_d  = 1'b1;
               end else begin
                  sync_cnt_d = sync_cnt_q + 8'd1;
               end
            end
            ST_DATA: ;
            default: state_d = ST_OFF;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_OFF;
         sync_cnt_q <= '0;
         link_up_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_cnt_q <= sync_cnt_d;
         link_up_q  <= link_up_d;
      end
   end

   // Encoder side is combinational so an accepted byte reaches it the same cycle
   assign s_ready   = (state_q == ST_DATA) && !comp_due;
   assign accept    = s_ready && s_valid;
   assign enc_valid = (state_q != ST_OFF);
   assign link_up   = link_up_q;

   always_comb begin
      enc_k    = 1'b0;
      enc_data = '0;
      case (state_q)
         ST_SYNC: begin
            enc_k    = 1'b1;
            enc_data = K28_5;
         end
         ST_DATA: begin
            if (accept) begin
               enc_data = s_data;
            end else begin
               enc_k    = 1'b1;
               enc_data = K28_5;
            end
         end
         default: ;
      endcase
   end

   b8b10_rd_track u_rd_track (
      .clk       (clk),
      .rst       (rst),
      .enc_code  (enc_code),
      .enc_valid (enc_valid),
      .enc_rd    (enc_rd),
      .code_err  (code_err)
   );

endmodule

// File: tb/tb_b8b10_tx_ctrl.sv
// Directed self-checking bench for b8b10_tx_ctrl (SYNC_LEN=4, CCOMP_PERIOD=4).
// Comp-comma expectations follow B8B10_CCOMP_EN when the bench is built with it.
module tb_b8b10_tx_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       link_en;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_ready;
   logic [7:0] enc_data;
   logic       enc_k;
   logic       enc_valid;
   logic       enc_rd;
   logic [9:0] enc_code;
   logic       link_up;
   logic       code_err;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned dc     = 0;

   always #5 clk = ~clk;

   b8b10_tx_ctrl #(
      .SYNC_LEN     (4),
      .CCOMP_PERIOD (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .link_en   (link_en),
      .s_data    (s_data),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .enc_data  (enc_data),
      .enc_k     (enc_k),
      .enc_valid (enc_valid),
      .enc_rd    (enc_rd),
      .enc_code  (enc_code),
      .link_up   (link_up),
      .code_err  (code_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit comp_due(input int unsigned c);
`ifdef B8B10_CCOMP_EN
      return (c % 4) == 3;
`else
      return 1'b0;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      dc++;
   endtask

   // Entered with link_en=1 and the DUT in OFF; leaves it in DATA cycle 0.
   task automatic sync_seq(input logic err_exp);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("sync_valid", enc_valid, 1'b1);
         chk("sync_k", enc_k, 1'b1);
         chk("sync_data", enc_data, 8'hBC);
         chk("sync_ready", s_ready, 1'b0);
         chk("sync_link_up", link_up, 1'b0);
         chk("sync_code_err", code_err, err_exp);
      end
      tick();
      dc = 0;
      chk("data0_link_up", link_up, 1'b1);
      chk("data0_ready", s_ready, 1'b1);
      chk("data0_valid", enc_valid, 1'b1);
      chk("data0_idle_k", enc_k, 1'b1);
      chk("data0_idle_data", enc_data, 8'hBC);
   endtask

   task automatic send_bytes(input logic [7:0] first, input int unsigned n);
      logic [7:0]  nb;
      int unsigned sent;
      nb   = first;
      sent = 0;
      for (int unsigned cyc = 0; cyc < 2 * n && sent < n; cyc++) begin
         s_valid = 1'b1;
         s_data  = nb;
         #1;
         if (comp_due(dc)) begin
            chk("comp_ready", s_ready, 1'b0);
            chk("comp_k", enc_k, 1'b1);
            chk("comp_data", enc_data, 8'hBC);
         end else begin
            chk("byte_ready", s_ready, 1'b1);
            chk("byte_k", enc_k, 1'b0);
            chk("byte_data", enc_data, nb);
            nb = nb + 8'd1;
            sent++;
         end
         tick();
      end
      s_valid = 1'b0;
      chk("byte_count", sent, n);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst      = 1'b0;
      link_en  = 1'b0;
      s_valid  = 1'b0;
      s_data   = 8'h00;
      enc_code = 10'b1111100000;
      #3;
      chk("rst_ready", s_ready, 1'b0);
      chk("rst_valid", enc_valid, 1'b0);
      chk("rst_k", enc_k, 1'b0);
      chk("rst_data", enc_data, 8'h00);
      chk("rst_rd", enc_rd, 1'b0);
      chk("rst_link_up", link_up, 1'b0);
      chk("rst_code_err", code_err, 1'b0);

      #9;
      rst     = 1'b1;
      link_en = 1'b1;
      sync_seq(1'b0);
      send_bytes(8'h00, 10);

      enc_code = 10'b1111100000;
      tick();
      chk("rd_w5_hold", enc_rd, 1'b0);
      enc_code = 10'b1111110000;
      tick();
      chk("rd_w6_pos", enc_rd, 1'b1);
      enc_code = 10'b1111000000;
      tick();
      chk("rd_w4_neg", enc_rd, 1'b0);
      enc_code = 10'b1111110000;
      tick();
      chk("rd_w6_pos2", enc_rd, 1'b1);
      chk("err_clean", code_err, 1'b0);
      enc_code = 10'b1111111000;
      tick();
      chk("err_w7_set", code_err, 1'b1);
      chk("rd_w7_pos", enc_rd, 1'b1);
      enc_code = 10'b1111100000;
      tick();
      chk("err_sticky", code_err, 1'b1);

      link_en = 1'b0;
      tick();
      chk("drop_valid", enc_valid, 1'b0);
      chk("drop_link_up", link_up, 1'b0);
      chk("drop_ready", s_ready, 1'b0);
      chk("drop_k", enc_k, 1'b0);
      chk("drop_data", enc_data, 8'h00);
      chk("drop_rd_kept", enc_rd, 1'b1);

      link_en = 1'b1;
      sync_seq(1'b1);
      send_bytes(8'h40, 8);

      rst = 1'b0;
      #1;
      chk("midrst_valid", enc_valid, 1'b0);
      chk("midrst_rd", enc_rd, 1'b0);
      chk("midrst_code_err", code_err, 1'b0);
      chk("midrst_link_up", link_up, 1'b0);
      #1;
      rst = 1'b1;
      sync_seq(1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
